jk_excitation_driver: RTL and testbench
=======================================

// Module: jk_excitation_driver
// PURPOSE
//   Drives a bank of external JK flip-flops to target values. Target words
//   arrive on a valid/ready interface and are buffered in a small FIFO.
//   For each word, the block computes per-bit J/K inputs from the JK
//   excitation table, applies them for one clock, then checks the flops' q.
//   Sits between a pattern source and any JK register bank; used for
//   bring-up and self-check of JK-based state registers.
// PARAMETERS
//   WIDTH       4  number of JK flops driven (1..32)
//   FIFO_DEPTH  4  target-word buffer depth (power of 2, >=2)
//   DC_POLICY   0  resolves don't-care J/K: 0 -> x=0 (set/reset style),
//                  1 -> x=1 (toggle style)
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous, active-low reset
//   tgt_data   in   WIDTH  target q value for the flop bank
//   tgt_valid  in   1      tgt_data valid
//   tgt_ready  out  1      FIFO can accept; a word transfers on valid&ready
//   q_in       in   WIDTH  readback of the external flop bank
//   j_out      out  WIDTH  J inputs to the flop bank
//   k_out      out  WIDTH  K inputs to the flop bank
//   busy       out  1      state!=IDLE or FIFO non-empty
//   done       out  1      1-cycle pulse: current word has been checked
//   mismatch   out  1      valid with done: q_in != target
//   err_count  out  8      saturating count of mismatches
// BEHAVIOUR
//   - Reset (rst_n=0 at edge): FIFO flushed, state=IDLE, err_count=0.
//     While rst_n=0: tgt_ready=0. After reset: j_out=k_out=0, done=0,
//     mismatch=0, busy=0, tgt_ready=1.
//   - Excitation, per bit (q->t): 0->0 J=0,K=x; 0->1 J=1,K=x;
//     1->0 J=x,K=1; 1->1 J=x,K=0. x is set by DC_POLICY.
//   - FSM states: IDLE, DRIVE, CHECK.
//     IDLE : j=k=0. If the FIFO is non-empty, pop the head into tgt_reg and go to DRIVE.
//     DRIVE: exactly 1 cycle. j_out/k_out = excite(q_in, tgt_reg),
//            combinational on q_in. Next state is CHECK.
//     CHECK: j=k=0. done=1. mismatch=(q_in!=tgt_reg).
//            err_count increments at the edge, saturating at 255.
//            If the FIFO is non-empty, pop and go to DRIVE; else go to IDLE.
//   - Latency: word accepted at edge N -> DRIVE in cycle N+1..N+2 ->
//     done in cycle N+2..N+3. Back-to-back throughput is 1 word per 2 cycles.
//   - FIFO: tgt_ready = !full. A push and a pop in the same cycle are both
//     legal, and count is unchanged. A pop never occurs when the FIFO is empty.
//     Order is strictly preserved.
//   - j_out/k_out are 0 in every state except DRIVE, so flops hold.
//   - Reset mid-DRIVE or mid-CHECK: the word is abandoned, with no done pulse.
//     j=k=0 from the next cycle. Queued words are discarded.
// STRUCTURE
//   - Package jk_drv_pkg: state enum {IDLE, DRIVE, CHECK}, DC_POLICY
//     constants, function excite(q, t, dc) returning {j, k}.
//   - Sub-module jk_drv_fifo: synchronous FIFO (WIDTH x FIFO_DEPTH) with
//     push/pop/full/empty and flush on reset.
//   - Top: FSM, tgt_reg, excitation logic, compare, err_count.
// TESTING
//   1. rst_n=0 for 2 cycles -> tgt_ready=0; after release: j/k=0,
//      err_count=0, busy=0, tgt_ready=1.
//   2. DC_POLICY=0, flops=0000, push 1010 -> DRIVE: j=1010, k=0000.
//      CHECK: q_in=1010, done=1, mismatch=0.
//   3. DC_POLICY=1, flops=1010, push 0110 -> DRIVE: j=1110, k=1101.
//      CHECK: q_in=0110, mismatch=0.
//   4. FIFO_DEPTH=4, hold DRIVE/CHECK busy, push 5 words back-to-back ->
//      tgt_ready falls after 4 in FIFO. All 5 words are driven in order,
//      with done spaced every 2 cycles.
//   5. Bench flop model with bit0 stuck at 0, push 0001 -> done=1,
//      mismatch=1, err_count=1. After 300 such words, err_count=255.
//   6. Queue 3 words, assert rst_n=0 during DRIVE -> j/k=0 next cycle,
//      no done, FIFO empty, no further drive after release.

Source files
------------

// File: rtl/jk_drv_pkg.sv
// Shared types and helpers for the JK excitation driver: FSM encoding,
// don't-care policy constants and the per-bit JK excitation function.
package jk_drv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Value substituted for the "x" entries of the excitation table.
  localparam logic DC_SET_RESET = 1'b0;
  localparam logic DC_TOGGLE    = 1'b1;

  localparam logic [7:0] ERR_MAX = 8'd255;

  // Returns {j, k} that moves a JK flop from q to t on the next edge.
  function automatic logic [1:0] excite(input logic q, input logic t, input logic dc);
    logic j;
    logic k;
    if (q) begin
      j = dc;
      k = ~t;
    end else begin
      j = t;
      k = dc;
    end
    return {j, k};
  endfunction

endpackage

// File: rtl/jk_drv_fifo.sv
// Target-word buffer: synchronous FIFO with wrap-bit pointers, flushed by
// the synchronous active-low reset. Push on full and pop on empty are ignored.
module jk_drv_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  a_no_pop_empty : assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));
  a_no_push_full : assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives a bank of external JK flops to buffered target words, one word per
// DRIVE/CHECK pair, and checks the readback against the target.
module jk_excitation_driver
  import jk_drv_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int DC_POLICY  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [7:0]       err_count,
  output logic [1:0]       fsm_state
);

  localparam logic DC = (DC_POLICY != 0) ? DC_TOGGLE : DC_SET_RESET;

  // Handshake: a word transfers on a rising edge where tgt_valid && tgt_ready;
  // tgt_ready depends only on FIFO fullness and reset, never on tgt_valid.
  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] tgt_reg;
  logic [WIDTH-1:0] drive_j;
  logic [WIDTH-1:0] drive_k;
  logic             word_mismatch;

  assign tgt_ready = rst_n & ~fifo_full;
  assign push      = tgt_valid & tgt_ready;

  jk_drv_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (tgt_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A new word may be taken both from IDLE and straight out of CHECK,
  // which is what gives one word every two cycles under load.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = DRIVE;
        end
      end
      DRIVE: state_next = CHECK;
      CHECK: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = DRIVE;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)   tgt_reg <= '0;
    else if (pop) tgt_reg <= fifo_rdata;
  end

  always_comb begin
    drive_j = '0;
    drive_k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {drive_j[i], drive_k[i]} = excite(q_in[i], tgt_reg[i], DC);
    end
  end

  assign word_mismatch = (q_in != tgt_reg);

  always_comb begin
    j_out    = '0;
    k_out    = '0;
    done     = 1'b0;
    mismatch = 1'b0;
    case (state)
      DRIVE: begin
        j_out = drive_j;
        k_out = drive_k;
      end
      CHECK: begin
        done     = 1'b1;
        mismatch = word_mismatch;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (state == CHECK && word_mismatch && err_count != ERR_MAX) begin
      err_count <= err_count + 8'd1;
    end
  end

  assign busy      = (state != IDLE) | ~fifo_empty;
  assign fsm_state = state;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: two instances (set/reset and toggle
// don't-care policy), each driving a behavioural JK flop bank.
module tb_jk_excitation_driver;
  import jk_drv_pkg::*;

  localparam int W  = 4;
  localparam int EW = 3 * W + 2;  // {known_jk, target, exp_j, exp_k, exp_mismatch}
  localparam logic [1:0] S_DRIVE = DRIVE;

  logic         clk;
  logic         rst_n;

  logic [W-1:0] tgt_data0, tgt_data1;
  logic         tgt_valid0, tgt_valid1;
  logic         tgt_ready0, tgt_ready1;
  logic [W-1:0] j0, k0, j1, k1;
  logic         busy0, busy1, done0, done1, mm0, mm1;
  logic [7:0]   err0, err1;
  logic [1:0]   st0, st1;

  logic [W-1:0] fq0, fq1;
  logic         load0, load1;
  logic [W-1:0] lval0, lval1;
  logic [W-1:0] stuck0;

  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  int            exp_err0, exp_err1;
  int            tests, fails;
  int            cyc;
  int            done_cyc[$];
  int            done_count0;
  int            stall_count;
  bit            mon_en;

  jk_excitation_driver #(.WIDTH(W), .FIFO_DEPTH(4), .DC_POLICY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .tgt_data(tgt_data0), .tgt_valid(tgt_valid0),
    .tgt_ready(tgt_ready0), .q_in(fq0), .j_out(j0), .k_out(k0), .busy(busy0),
    .done(done0), .mismatch(mm0), .err_count(err0), .fsm_state(st0)
  );

  jk_excitation_driver #(.WIDTH(W), .FIFO_DEPTH(4), .DC_POLICY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tgt_data(tgt_data1), .tgt_valid(tgt_valid1),
    .tgt_ready(tgt_ready1), .q_in(fq1), .j_out(j1), .k_out(k1), .busy(busy1),
    .done(done1), .mismatch(mm1), .err_count(err1), .fsm_state(st1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External JK flop banks; bank 0 can have bits stuck at 0.
  always @(posedge clk) begin
    if (load0) fq0 <= lval0;
    else       fq0 <= ((j0 & ~fq0) | (~k0 & fq0)) & ~stuck0;
    if (load1) fq1 <= lval1;
    else       fq1 <= (j1 & ~fq1) | (~k1 & fq1);
  end

  function automatic logic [2*W-1:0] model_excite(input logic [W-1:0] q, input logic [W-1:0] t,
                                                  input logic dc);
    logic [W-1:0] j, k;
    for (int i = 0; i < W; i++) begin
      case ({q[i], t[i]})
        2'b00:   begin j[i] = 1'b0; k[i] = dc;   end
        2'b01:   begin j[i] = 1'b1; k[i] = dc;   end
        2'b10:   begin j[i] = dc;   k[i] = 1'b1; end
        default: begin j[i] = dc;   k[i] = 1'b0; end
      endcase
    end
    return {j, k};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event with no expectation (t=%0t)", name, $time);
  endtask

  // scoreboard monitor
  task automatic mon_step(input int id);
    logic [EW-1:0]  e;
    logic [1:0]     st;
    logic [W-1:0]   j, k, q, tgt;
    logic           d, m, dc;
    logic [7:0]     ec;
    logic [2*W-1:0] ejk;
    int             qsz;
    if (id == 0) begin
      st = st0; j = j0; k = k0; q = fq0; d = done0; m = mm0; ec = err0; dc = 1'b0;
      qsz = exp_q0.size();
    end else begin
      st = st1; j = j1; k = k1; q = fq1; d = done1; m = mm1; ec = err1; dc = 1'b1;
      qsz = exp_q1.size();
    end
    if (st == S_DRIVE) begin
      if (qsz == 0) begin
        fail_now($sformatf("drive_no_word%0d", id));
      end else begin
        e   = (id == 0) ? exp_q0[0] : exp_q1[0];
        tgt = e[EW-2 -: W];
        ejk = e[EW-1] ? e[2*W -: 2*W] : model_excite(q, tgt, dc);
        check($sformatf("drive_jk%0d tgt=%b", id, tgt), 32'({j, k}), 32'(ejk));
      end
    end else begin
      check($sformatf("hold_jk%0d", id), 32'({j, k}), 32'd0);
    end
    if (d) begin
      if (qsz == 0) begin
        fail_now($sformatf("done_no_word%0d", id));
      end else begin
        e = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check($sformatf("mismatch%0d tgt=%b", id, e[EW-2 -: W]), 32'(m), 32'(e[0]));
        if (id == 0) begin
          check("err_count0", 32'(ec), 32'(exp_err0));
          if (e[0] && exp_err0 < 255) exp_err0++;
          done_cyc.push_back(cyc);
          done_count0++;
        end else begin
          check("err_count1", 32'(ec), 32'(exp_err1));
          if (e[0] && exp_err1 < 255) exp_err1++;
        end
      end
    end
    if (!rst_n) begin
      if (id == 0) begin exp_q0.delete(); exp_err0 = 0; end
      else         begin exp_q1.delete(); exp_err1 = 0; end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      mon_step(0);
      mon_step(1);
    end
  end

  // driver
  task automatic push_word(input int id, input logic [W-1:0] t, input logic known,
                           input logic [W-1:0] ej, input logic [W-1:0] ek, input logic mm);
    int   waited;
    logic rdy;
    waited = 0;
    rdy    = 1'b0;
    if (id == 0) begin tgt_data0 = t; tgt_valid0 = 1'b1; end
    else         begin tgt_data1 = t; tgt_valid1 = 1'b1; end
    while (1) begin
      @(negedge clk);
      rdy = (id == 0) ? tgt_ready0 : tgt_ready1;
      if (rdy) break;
      stall_count++;
      waited++;
      if (waited > 50) begin
        fail_now($sformatf("ready_timeout%0d", id));
        break;
      end
      @(posedge clk);
      #1;
    end
    if (rdy) begin
      if (id == 0) exp_q0.push_back({known, t, ej, ek, mm});
      else         exp_q1.push_back({known, t, ej, ek, mm});
    end
    @(posedge clk);
    #1;
    tgt_valid0 = 1'b0;
    tgt_valid1 = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy0 || busy1) && n < 3000);
    if (busy0 || busy1) fail_now("idle_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    int dc_before;
    logic [W-1:0] burst [8];
    tests = 0; fails = 0; cyc = 0; done_count0 = 0; stall_count = 0;
    exp_err0 = 0; exp_err1 = 0; mon_en = 1'b0;
    rst_n = 1'b0;
    tgt_data0 = '0; tgt_data1 = '0; tgt_valid0 = 1'b0; tgt_valid1 = 1'b0;
    load0 = 1'b1; load1 = 1'b1; lval0 = '0; lval1 = '0; stuck0 = '0;

    // 1: reset behaviour
    @(negedge clk);
    check("rst_ready0", 32'(tgt_ready0), 32'd0);
    check("rst_ready1", 32'(tgt_ready1), 32'd0);
    @(negedge clk);
    check("rst_ready0_b", 32'(tgt_ready0), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; load0 = 1'b0; load1 = 1'b0; mon_en = 1'b1;
    @(negedge clk);
    check("post_rst_jk0", 32'({j0, k0}), 32'd0);
    check("post_rst_err0", 32'(err0), 32'd0);
    check("post_rst_busy0", 32'(busy0), 32'd0);
    check("post_rst_ready0", 32'(tgt_ready0), 32'd1);
    check("post_rst_done0", 32'(done0), 32'd0);
    check("post_rst_mm0", 32'(mm0), 32'd0);
    check("post_rst_busy1", 32'(busy1), 32'd0);
    check("post_rst_ready1", 32'(tgt_ready1), 32'd1);
    @(posedge clk);
    #1;

    // 2: set/reset policy, flops 0000 -> 1010
    push_word(0, 4'b1010, 1'b1, 4'b1010, 4'b0000, 1'b0);
    wait_idle();

    // 3: toggle policy, flops 1010 -> 0110
    load1 = 1'b1; lval1 = 4'b1010;
    @(posedge clk);
    #1;
    load1 = 1'b0;
    push_word(1, 4'b0110, 1'b1, 4'b1110, 4'b1101, 1'b0);
    wait_idle();

    // 4: back-to-back burst, fills the FIFO once
    burst = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111, 4'b0000, 4'b0110, 4'b1100};
    done_cyc.delete();
    stall_count = 0;
    for (int i = 0; i < 8; i++) push_word(0, burst[i], 1'b0, '0, '0, 1'b0);
    wait_idle();
    check("burst_stalls", 32'(stall_count), 32'd1);
    check("burst_done_count", 32'(done_cyc.size()), 32'd8);
    for (int i = 1; i < done_cyc.size(); i++)
      check($sformatf("done_spacing%0d", i), 32'(done_cyc[i] - done_cyc[i-1]), 32'd2);

    // 5: bit0 stuck at 0; flops are 1100 here
    stuck0 = 4'b0001;
    push_word(0, 4'b0001, 1'b1, 4'b0001, 4'b1100, 1'b1);
    wait_idle();
    check("err_after_one", 32'(err0), 32'd1);
    for (int i = 0; i < 299; i++) push_word(0, 4'b0001, 1'b0, '0, '0, 1'b1);
    wait_idle();
    check("err_saturated", 32'(err0), 32'd255);
    stuck0 = '0;

    // 6: reset during DRIVE with words still queued
    push_word(0, 4'b0011, 1'b0, '0, '0, 1'b0);
    push_word(0, 4'b0101, 1'b0, '0, '0, 1'b0);
    push_word(0, 4'b1001, 1'b0, '0, '0, 1'b0);
    begin
      int n;
      n = 0;
      while (st0 != S_DRIVE && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (st0 != S_DRIVE) fail_now("reach_drive");
    end
    dc_before = done_count0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_jk0", 32'({j0, k0}), 32'd0);
    check("abort_busy0", 32'(busy0), 32'd0);
    check("abort_ready0", 32'(tgt_ready0), 32'd1);
    check("abort_err0", 32'(err0), 32'd0);
    repeat (10) @(negedge clk);
    check("abort_no_done", 32'(done_count0), 32'(dc_before));
    check("abort_still_idle", 32'(busy0), 32'd0);

    // leftover expectations mean a word was never checked
    check("exp_q0_drained", 32'(exp_q0.size()), 32'd0);
    check("exp_q1_drained", 32'(exp_q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
